// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with a valid/ready handshake.
// A 2-entry store (output register + skid register) absorbs back-pressure.
// Build option: define DECODE_MEXT_EN to decode the M-extension (funct7=0000001)
// on ALU_REG opcodes.
// alu_funct encoding: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLTU=6 SLL=7 SRL=8 SRA=9
//                     MUL=10 MULH=11 MULHSU=12 MULHU=13 DIV=14 DIVU=15 REM=16 REMU=17
`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 5
`endif

module decode_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 instr,
    input  logic [XLEN-1:0]             pc_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             pc_out,
    output logic [`ALU_FUNCT_WIDTH-1:0] alu_funct,
    output logic [REG_ADDR_W-1:0]       rs1,
    output logic [REG_ADDR_W-1:0]       rs2,
    output logic [REG_ADDR_W-1:0]       rd,
    output logic [XLEN-1:0]             immed,
    output logic                        illegal
);

    localparam int AW = `ALU_FUNCT_WIDTH;

    localparam logic [AW-1:0] ALU_ADD    = AW'(0);
    localparam logic [AW-1:0] ALU_SUB    = AW'(1);
    localparam logic [AW-1:0] ALU_AND    = AW'(2);
    localparam logic [AW-1:0] ALU_OR     = AW'(3);
    localparam logic [AW-1:0] ALU_XOR    = AW'(4);
    localparam logic [AW-1:0] ALU_SLT    = AW'(5);
    localparam logic [AW-1:0] ALU_SLTU   = AW'(6);
    localparam logic [AW-1:0] ALU_SLL    = AW'(7);
    localparam logic [AW-1:0] ALU_SRL    = AW'(8);
    localparam logic [AW-1:0] ALU_SRA    = AW'(9);
`ifdef DECODE_MEXT_EN
    localparam logic [AW-1:0] ALU_MUL    = AW'(10);
`endif

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OP_ALU_REG = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SRL  = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT1 = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [AW-1:0]         alu;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       imm;
        logic                  ill;
    } bundle_t;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, imm_sh_s;
    logic [AW-1:0]   dec_alu_s;
    logic [XLEN-1:0] dec_imm_s;
    logic            dec_ill_s;
    bundle_t         dec_s;

    bundle_t or_q, or_d, sk_q, sk_d;
    logic    or_valid_q, or_valid_d, sk_valid_q, sk_valid_d, in_ready_q, in_ready_d;
    logic    accept_s, or_free_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];

    // Sign-extending casts of each immediate format; shamt is zero-extended.
    assign imm_i_s  = XLEN'($signed(instr[31:20]));
    assign imm_s_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b_s  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u_s  = XLEN'($signed({instr[31:12], 12'h000}));
    assign imm_j_s  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign imm_sh_s = XLEN'(instr[24:20]);

    // Opcode/funct decode into immediate, ALU operation and illegal flag.
    always_comb begin
        dec_imm_s = '0;
        dec_alu_s = ALU_ADD;
        dec_ill_s = 1'b0;
        case (opcode_s)
            OP_LOAD, OP_JALR:  dec_imm_s = imm_i_s;
            OP_STORE:          dec_imm_s = imm_s_s;
            OP_BRANCH:         dec_imm_s = imm_b_s;
            OP_JAL:            dec_imm_s = imm_j_s;
            OP_LUI, OP_AUIPC:  dec_imm_s = imm_u_s;
            OP_ALU_IMM: begin
                if (funct3_s == F3_SLL || funct3_s == F3_SRL) begin
                    dec_imm_s = imm_sh_s;
                end else begin
                    dec_imm_s = imm_i_s;
                end
                case (funct3_s)
                    F3_ADD:  dec_alu_s = ALU_ADD;
                    F3_SLL: begin
                        dec_alu_s = ALU_SLL;
                        dec_ill_s = (funct7_s != F7_BASE);
                    end
                    F3_SLT:  dec_alu_s = ALU_SLT;
                    F3_SLTU: dec_alu_s = ALU_SLTU;
                    F3_XOR:  dec_alu_s = ALU_XOR;
                    F3_SRL: begin
                        if (funct7_s == F7_BASE) begin
                            dec_alu_s = ALU_SRL;
                        end else if (funct7_s == F7_ALT1) begin
                            dec_alu_s = ALU_SRA;
                        end else begin
                            dec_alu_s = ALU_ADD;
                            dec_ill_s = 1'b1;
                        end
                    end
                    F3_OR:   dec_alu_s = ALU_OR;
                    F3_AND:  dec_alu_s = ALU_AND;
                    default: dec_alu_s = ALU_ADD;
                endcase
            end
            OP_ALU_REG: begin
                if (funct7_s == F7_MEXT) begin
`ifdef DECODE_MEXT_EN
                    dec_alu_s = ALU_MUL + AW'(funct3_s);
`else
                    dec_alu_s = ALU_ADD;
                    dec_ill_s = 1'b1;
`endif
                end else if (funct7_s != F7_BASE && funct7_s != F7_ALT1) begin
                    dec_alu_s = ALU_ADD;
                    dec_ill_s = 1'b1;
                end else begin
                    // ALT1 is only meaningful for ADD (->SUB) and SRL (->SRA).
                    dec_ill_s = (funct7_s == F7_ALT1) && (funct3_s != F3_ADD) && (funct3_s != F3_SRL);
                    case (funct3_s)
                        F3_ADD:  dec_alu_s = (funct7_s == F7_ALT1) ? ALU_SUB : ALU_ADD;
                        F3_SLL:  dec_alu_s = ALU_SLL;
                        F3_SLT:  dec_alu_s = ALU_SLT;
                        F3_SLTU: dec_alu_s = ALU_SLTU;
                        F3_XOR:  dec_alu_s = ALU_XOR;
                        F3_SRL:  dec_alu_s = (funct7_s == F7_ALT1) ? ALU_SRA : ALU_SRL;
                        F3_OR:   dec_alu_s = ALU_OR;
                        F3_AND:  dec_alu_s = ALU_AND;
                        default: dec_alu_s = ALU_ADD;
                    endcase
                end
            end
            default: dec_ill_s = 1'b1;
        endcase
    end

    assign dec_s = '{pc:  pc_in,
                     alu: dec_alu_s,
                     rs1: REG_ADDR_W'(instr[19:15]),
                     rs2: REG_ADDR_W'(instr[24:20]),
                     rd:  REG_ADDR_W'(instr[11:7]),
                     imm: dec_imm_s,
                     ill: dec_ill_s};

    assign accept_s  = in_valid & in_ready_q;
    assign or_free_s = ~or_valid_q | out_ready;

    // Next state of output/skid registers: flush first, then drain/refill, then skid capture.
    always_comb begin
        or_d       = or_q;
        sk_d       = sk_q;
        or_valid_d = or_valid_q;
        sk_valid_d = sk_valid_q;
        if (flush) begin
            or_valid_d = 1'b0;
            sk_valid_d = 1'b0;
        end else if (or_free_s) begin
            if (sk_valid_q) begin
                // in_ready is low while the skid is full, so nothing new arrives here.
                or_d       = sk_q;
                or_valid_d = 1'b1;
                sk_valid_d = 1'b0;
            end else if (accept_s) begin
                or_d       = dec_s;
                or_valid_d = 1'b1;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (accept_s) begin
            sk_d       = dec_s;
            sk_valid_d = 1'b1;
        end else begin
            sk_valid_d = sk_valid_q;
        end
        in_ready_d = ~sk_valid_d;
    end

    // State registers with synchronous reset to an empty, ready stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            or_q       <= '0;
            sk_q       <= '0;
            or_valid_q <= 1'b0;
            sk_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            or_q       <= or_d;
            sk_q       <= sk_d;
            or_valid_q <= or_valid_d;
            sk_valid_q <= sk_valid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = or_valid_q;
    assign pc_out    = or_q.pc;
    assign alu_funct = or_q.alu;
    assign rs1       = or_q.rs1;
    assign rs2       = or_q.rs2;
    assign rd        = or_q.rd;
    assign immed     = or_q.imm;
    assign illegal   = or_q.ill;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed, table-driven bench for decode_stage.
// Honors DECODE_MEXT_EN for the expected result of the mul vector.
`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 5
`endif

module tb_decode_stage;

    localparam logic [4:0] A_ADD  = 5'd0;
    localparam logic [4:0] A_SUB  = 5'd1;
    localparam logic [4:0] A_AND  = 5'd2;
    localparam logic [4:0] A_SLTU = 5'd6;
    localparam logic [4:0] A_SLL  = 5'd7;
    localparam logic [4:0] A_SRA  = 5'd9;
    localparam logic [4:0] A_MUL  = 5'd10;
    localparam int NV = 16;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, illegal;
    logic [31:0] instr, pc_in, pc_out, immed;
    logic [4:0]  alu_funct, rs1, rs2, rd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs [NV];

    decode_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .alu_funct(alu_funct),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .immed(immed), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        instr    = ins;
        pc_in    = pc;
    endtask

    initial begin
        vecs[0]  = '{32'hFFF10093, A_ADD,  5'd2,  5'd31, 5'd1,  32'hFFFFFFFF, 1'b0}; // addi x1,x2,-1
        vecs[1]  = '{32'h402081B3, A_SUB,  5'd1,  5'd2,  5'd3,  32'h00000000, 1'b0}; // sub
        vecs[2]  = '{32'h4030D093, A_SRA,  5'd1,  5'd3,  5'd1,  32'h00000003, 1'b0}; // srai
        vecs[3]  = '{32'h00512423, A_ADD,  5'd2,  5'd5,  5'd8,  32'h00000008, 1'b0}; // sw
        vecs[4]  = '{32'h001000EF, A_ADD,  5'd0,  5'd1,  5'd1,  32'h00000800, 1'b0}; // jal
        vecs[5]  = '{32'h123452B7, A_ADD,  5'd8,  5'd3,  5'd5,  32'h12345000, 1'b0}; // lui
        vecs[6]  = '{32'hFE208EE3, A_ADD,  5'd1,  5'd2,  5'd29, 32'hFFFFFFFC, 1'b0}; // beq -4
        vecs[7]  = '{32'h0000007F, A_ADD,  5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1}; // bad opcode
`ifdef DECODE_MEXT_EN
        vecs[8]  = '{32'h02208033, A_MUL,  5'd1,  5'd2,  5'd0,  32'h00000000, 1'b0}; // mul
`else
        vecs[8]  = '{32'h02208033, A_ADD,  5'd1,  5'd2,  5'd0,  32'h00000000, 1'b1}; // mul
`endif
        vecs[9]  = '{32'h40509093, A_SLL,  5'd1,  5'd5,  5'd1,  32'h00000005, 1'b1}; // slli bad f7
        vecs[10] = '{32'h0430D093, A_ADD,  5'd1,  5'd3,  5'd1,  32'h00000003, 1'b1}; // srli bad f7
        vecs[11] = '{32'hFF83A303, A_ADD,  5'd7,  5'd24, 5'd6,  32'hFFFFFFF8, 1'b0}; // lw -8
        vecs[12] = '{32'h0062F233, A_AND,  5'd5,  5'd6,  5'd4,  32'h00000000, 1'b0}; // and
        vecs[13] = '{32'hFFFFF517, A_ADD,  5'd31, 5'd31, 5'd10, 32'hFFFFF000, 1'b0}; // auipc
        vecs[14] = '{32'h4020B033, A_SLTU, 5'd1,  5'd2,  5'd0,  32'h00000000, 1'b1}; // ALT1 sltu
        vecs[15] = '{32'h40010093, A_ADD,  5'd2,  5'd0,  5'd1,  32'h00000400, 1'b0}; // addi 1024

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = 32'h0; pc_in = 32'h0;

        // Reset state
        tick(); tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_immed",     immed,              32'd0);
        check("rst_pc_out",    pc_out,             32'd0);
        rst = 1'b0;
        tick();
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_in_ready",  {31'd0, in_ready},  32'd1);

        // Decode table, one instruction per cycle with a free consumer
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].ins, 32'h1000 + 32'(i) * 32'd4);
            tick();
            in_valid = 1'b0;
            check($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("v%0d_pc", i),    pc_out, 32'h1000 + 32'(i) * 32'd4);
            check($sformatf("v%0d_alu", i),   {27'd0, alu_funct}, {27'd0, vecs[i].alu});
            check($sformatf("v%0d_regs", i),  {17'd0, rs1, rs2, rd},
                  {17'd0, vecs[i].rs1, vecs[i].rs2, vecs[i].rd});
            check($sformatf("v%0d_imm", i),   immed, vecs[i].imm);
            check($sformatf("v%0d_ill", i),   {31'd0, illegal}, {31'd0, vecs[i].ill});
        end
        tick();
        check("drain_empty", {31'd0, out_valid}, 32'd0);

        // Back-pressure: A to output reg, B to skid, then drain in order
        out_ready = 1'b0;
        send(32'hFFF10093, 32'h2000);
        tick();
        check("bp_a_valid", {31'd0, out_valid}, 32'd1);
        check("bp_a_ready", {31'd0, in_ready},  32'd1);
        send(32'h402081B3, 32'h2004);
        tick();
        check("bp_skid_ready", {31'd0, in_ready}, 32'd0);
        check("bp_a_held_pc",  pc_out, 32'h2000);
        send(32'h0062F233, 32'h2008);   // offered while not ready: must not be taken
        tick();
        in_valid = 1'b0;
        check("bp_hold_pc",    pc_out, 32'h2000);
        check("bp_hold_alu",   {27'd0, alu_funct}, {27'd0, A_ADD});
        check("bp_hold_imm",   immed, 32'hFFFFFFFF);
        check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("bp_b_valid", {31'd0, out_valid}, 32'd1);
        check("bp_b_pc",    pc_out, 32'h2004);
        check("bp_b_alu",   {27'd0, alu_funct}, {27'd0, A_SUB});
        check("bp_b_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp_done", {31'd0, out_valid}, 32'd0);

        // Flush with both registers full and a new instruction offered
        out_ready = 1'b0;
        send(32'hFFF10093, 32'h3000);
        tick();
        send(32'h402081B3, 32'h3004);
        tick();
        check("fl_full_ready", {31'd0, in_ready}, 32'd0);
        send(32'h0062F233, 32'h3008);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_in_ready",  {31'd0, in_ready},  32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("fl_quiet%0d", k), {31'd0, out_valid}, 32'd0);
        end
        send(32'h00512423, 32'h300C);
        tick();
        in_valid = 1'b0;
        check("fl_next_valid", {31'd0, out_valid}, 32'd1);
        check("fl_next_pc",    pc_out, 32'h300C);

        // Flush with only the output register full and an input offered
        out_ready = 1'b0;
        send(32'hFFF10093, 32'h4000);
        tick();
        send(32'h402081B3, 32'h4004);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl1_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl1_in_ready",  {31'd0, in_ready},  32'd1);
        out_ready = 1'b1;
        tick();
        check("fl1_quiet", {31'd0, out_valid}, 32'd0);

        // Reset together with flush while full
        out_ready = 1'b0;
        send(32'hFFF10093, 32'h5000);
        tick();
        send(32'h402081B3, 32'h5004);
        tick();
        in_valid = 1'b0;
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        check("rf_out_valid", {31'd0, out_valid}, 32'd0);
        check("rf_in_ready",  {31'd0, in_ready},  32'd1);
        check("rf_immed",     immed,  32'd0);
        check("rf_pc_out",    pc_out, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
